// File: rtl/math_pow2_pipe.sv
// Pipelined base-2 antilog: dout = floor(2^x * 2^OUT_FRAC_W), x = din / 2^FRAC_W.
// Three stages: field split, LUT read with optional interpolation, shift and clip.
module math_pow2_pipe #(
    parameter int INT_W      = 6,
    parameter int FRAC_W     = 6,
    parameter int SIGNED     = 0,
    parameter int LUT_BITS   = 6,
    parameter int LUT_W      = 23,
    parameter int OUT_INT_W  = 16,
    parameter int OUT_FRAC_W = 8
) (
    input  logic                            clk,
    input  logic                            rst,
    input  logic                            ena,
    input  logic                            in_valid,
    input  logic [INT_W+FRAC_W-1:0]         din,
    output logic                            out_valid,
    output logic [OUT_INT_W+OUT_FRAC_W-1:0] dout,
    output logic                            sat,
    output logic                            uflow
);

    localparam int IN_W   = INT_W + FRAC_W;
    localparam int OUT_W  = OUT_INT_W + OUT_FRAC_W;
    localparam int D      = FRAC_W - LUT_BITS;
    localparam int DEPTH  = 2 ** LUT_BITS;
    localparam int DROP   = LUT_W - OUT_FRAC_W;
    localparam int E_MAX  = (SIGNED != 0) ? (2 ** (INT_W - 1)) - 1 : (2 ** INT_W) - 1;
    // Exponents at or above OUT_INT_W saturate, so the shifter only has to cover the rest.
    localparam int SH_MAX = (E_MAX < OUT_INT_W - 1) ? E_MAX : OUT_INT_W - 1;
    localparam int WIDE_W = LUT_W + 1 + SH_MAX;

    // round((2^(idx/DEPTH) - 1) * 2^LUT_W); idx = DEPTH yields exactly 2^LUT_W.
    function automatic logic [LUT_W:0] lut_entry(input int idx);
        real    scaled;
        longint v;
        scaled = (2.0 ** (real'(idx) / real'(DEPTH)) - 1.0) * (2.0 ** LUT_W) + 0.5;
        v = longint'(scaled);
        if (real'(v) > scaled) v = v - 1;
        return (LUT_W + 1)'(v);
    endfunction

    logic [LUT_W:0] lut [DEPTH+1];

    for (genvar g = 0; g <= DEPTH; g++) begin : g_lut
        assign lut[g] = lut_entry(g);
    end

    // Stage 1: split the exponent into integer part and LUT address.
    logic                s1_v;
    logic [INT_W-1:0]    s1_e;
    logic [LUT_BITS-1:0] s1_k;

    // NOTE: clocked state is written with <= only; the combinational block below uses =.
    always_ff @(posedge clk) begin
        if (rst) begin
            s1_v <= 1'b0;
            s1_e <= '0;
            s1_k <= '0;
        end else if (ena) begin
            s1_v <= in_valid;
            s1_e <= din[IN_W-1:FRAC_W];
            s1_k <= din[FRAC_W-1:D];
        end
    end

    // Stage 2 combinational: mantissa from the LUT, interpolated on the residue bits.
    logic [LUT_W-1:0]  m_next;
    logic [LUT_BITS:0] k_lo;

    assign k_lo = {1'b0, s1_k};

    if (D == 0) begin : g_direct
        assign m_next = LUT_W'(lut[k_lo]);
    end else begin : g_interp
        logic [D-1:0]       r_q;
        logic [LUT_BITS:0]  k_hi;
        logic [LUT_W:0]     step;
        logic [LUT_W+D-1:0] prod;

        always_ff @(posedge clk) begin
            if (rst) begin
                r_q <= '0;
            end else if (ena) begin
                r_q <= din[D-1:0];
            end
        end

        assign k_hi   = k_lo + (LUT_BITS + 1)'(1);
        assign step   = lut[k_hi] - lut[k_lo];
        assign prod   = (LUT_W + D)'(step) * (LUT_W + D)'(r_q);
        assign m_next = LUT_W'(lut[k_lo] + (LUT_W + 1)'(prod >> D));
    end

    logic             s2_v;
    logic [INT_W-1:0] s2_e;
    logic [LUT_W-1:0] s2_m;

    always_ff @(posedge clk) begin
        if (rst) begin
            s2_v <= 1'b0;
            s2_e <= '0;
            s2_m <= '0;
        end else if (ena) begin
            s2_v <= s1_v;
            s2_e <= s1_e;
            s2_m <= m_next;
        end
    end

    // Stage 3 combinational: scale 1.m by 2^e, then clip or flush.
    int                e_val;
    logic [LUT_W:0]    p;
    logic [WIDE_W-1:0] wide;
    logic [OUT_W-1:0]  dout_next;
    logic              sat_next;
    logic              uflow_next;

    always_comb begin
        // NOTE: every variable gets a default up front so no path leaves a latch behind.
        e_val      = (SIGNED != 0) ? int'($signed(s2_e)) : int'(s2_e);
        p          = {1'b1, s2_m};
        wide       = '0;
        dout_next  = '0;
        sat_next   = 1'b0;
        uflow_next = 1'b0;
        if (e_val >= OUT_INT_W) begin
            dout_next = '1;
            sat_next  = 1'b1;
        end else if (e_val < -OUT_FRAC_W) begin
            uflow_next = 1'b1;
        end else if (e_val >= 0) begin
            wide      = WIDE_W'(p) << e_val;
            dout_next = OUT_W'(wide >> DROP);
        end else begin
            dout_next = OUT_W'(p >> (DROP - e_val));
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            out_valid <= 1'b0;
            dout      <= '0;
            sat       <= 1'b0;
            uflow     <= 1'b0;
        end else if (ena) begin
            out_valid <= s2_v;
            dout      <= dout_next;
            sat       <= sat_next;
            uflow     <= uflow_next;
        end
    end

endmodule

// File: tb/tb_math_pow2_pipe.sv
// Bench for math_pow2_pipe: default, signed and interpolating instances checked
// against fixed vectors and an arithmetic reference model with a 3-edge delay.
module tb_math_pow2_pipe;

    typedef struct {
        bit     valid;
        bit     chk;
        longint dout;
        bit     sat;
        bit     uflow;
    } exp_t;

    typedef struct {
        int          dut;
        logic [15:0] din;
        longint      dout;
        bit          sat;
        bit          uflow;
    } vec_t;

    localparam int HN = 64;
    localparam int NV = 18;

    logic        clk = 1'b0;
    logic        rst;
    logic        ena;
    logic        iv [3];
    logic [11:0] din0;
    logic [11:0] din1;
    logic [13:0] din2;
    logic        ov [3];
    logic [23:0] dq [3];
    logic        sq [3];
    logic        uq [3];

    int    n_cmp = 0;
    int    n_bad = 0;
    exp_t  hist [3][HN];
    int    ncap [3];
    exp_t  cur [3];
    string nm [3] = '{"plain", "signed", "interp"};

    always #5 clk = ~clk;

    math_pow2_pipe u_plain (
        .clk(clk), .rst(rst), .ena(ena), .in_valid(iv[0]), .din(din0),
        .out_valid(ov[0]), .dout(dq[0]), .sat(sq[0]), .uflow(uq[0])
    );

    math_pow2_pipe #(.SIGNED(1)) u_signed (
        .clk(clk), .rst(rst), .ena(ena), .in_valid(iv[1]), .din(din1),
        .out_valid(ov[1]), .dout(dq[1]), .sat(sq[1]), .uflow(uq[1])
    );

    math_pow2_pipe #(.FRAC_W(8)) u_interp (
        .clk(clk), .rst(rst), .ena(ena), .in_valid(iv[2]), .din(din2),
        .out_valid(ov[2]), .dout(dq[2]), .sat(sq[2]), .uflow(uq[2])
    );

    function automatic longint lut_val(input int k);
        real x;
        x = (2.0 ** (real'(k) / 64.0) - 1.0) * 8388608.0;
        return longint'($floor(x + 0.5));
    endfunction

    // Reference: x = din / 2^fw, result = floor(2^x * 256) via LUT + linear interpolation.
    function automatic exp_t model(input int idx, input bit v, input logic [15:0] d);
        exp_t   x;
        int     fw, dd, e, f, k, r;
        longint lo, hi, m, p;
        fw = (idx == 2) ? 8 : 6;
        dd = fw - 6;
        e  = int'(d >> fw) & 63;
        if (idx == 1 && e >= 32) e = e - 64;
        f  = int'(d) & ((1 << fw) - 1);
        k  = f >> dd;
        r  = f & ((1 << dd) - 1);
        lo = lut_val(k);
        hi = lut_val(k + 1);
        m  = lo + ((hi - lo) * r) / (longint'(1) << dd);
        p  = (longint'(1) << 23) + m;
        x.valid = v;
        x.chk   = v;
        x.sat   = 1'b0;
        x.uflow = 1'b0;
        if (e >= 16) begin
            x.dout = (longint'(1) << 24) - 1;
            x.sat  = 1'b1;
        end else if (e < -8) begin
            x.dout  = 0;
            x.uflow = 1'b1;
        end else if (e >= 0) begin
            x.dout = (p * (longint'(1) << e)) / (longint'(1) << 15);
        end else begin
            x.dout = p / (longint'(1) << (15 - e));
        end
        return x;
    endfunction

    task automatic check(input string name, input longint act, input longint exp);
        n_cmp++;
        if (act != exp) begin
            n_bad++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Drive one cycle, advance the model at the edge, compare 1 time unit later.
    task automatic cycle(input bit r, input bit en, input bit [2:0] v,
                         input logic [15:0] d0, input logic [15:0] d1, input logic [15:0] d2);
        logic [15:0] dd [3];
        dd[0] = d0;
        dd[1] = d1;
        dd[2] = d2;
        rst   = r;
        ena   = en;
        iv[0] = v[0];
        iv[1] = v[1];
        iv[2] = v[2];
        din0  = d0[11:0];
        din1  = d1[11:0];
        din2  = d2[13:0];
        @(posedge clk);
        for (int i = 0; i < 3; i++) begin
            if (r) begin
                ncap[i] = 0;
                cur[i]  = '{1'b0, 1'b1, 64'd0, 1'b0, 1'b0};
            end else if (en) begin
                hist[i][ncap[i] % HN] = model(i, v[i], dd[i]);
                ncap[i]++;
                if (ncap[i] >= 3) begin
                    cur[i]     = hist[i][(ncap[i] - 3) % HN];
                    cur[i].chk = cur[i].valid;
                end else begin
                    cur[i] = '{1'b0, 1'b0, 64'd0, 1'b0, 1'b0};
                end
            end
        end
        #1;
        for (int i = 0; i < 3; i++) begin
            check($sformatf("%s out_valid", nm[i]), longint'(ov[i]), longint'(cur[i].valid));
            if (cur[i].chk) begin
                check($sformatf("%s dout", nm[i]), longint'(dq[i]), cur[i].dout);
                check($sformatf("%s sat", nm[i]), longint'(sq[i]), longint'(cur[i].sat));
                check($sformatf("%s uflow", nm[i]), longint'(uq[i]), longint'(cur[i].uflow));
            end
        end
    endtask

    initial begin
        vec_t        vecs [NV];
        int          first_valid;
        int          n;
        bit [2:0]    vv;
        logic [15:0] d [3];
        bit          stall_pat [7] = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1};

        vecs[0]  = '{0, 16'd0,     256,      1'b0, 1'b0};
        vecs[1]  = '{0, 16'd1,     258,      1'b0, 1'b0};
        vecs[2]  = '{0, 16'd224,   2896,     1'b0, 1'b0};
        vecs[3]  = '{0, 16'd1023,  16596492, 1'b0, 1'b0};
        vecs[4]  = '{0, 16'd64,    512,      1'b0, 1'b0};
        vecs[5]  = '{0, 16'd960,   8388608,  1'b0, 1'b0};
        vecs[6]  = '{0, 16'd1024,  16777215, 1'b1, 1'b0};
        vecs[7]  = '{0, 16'd4095,  16777215, 1'b1, 1'b0};
        vecs[8]  = '{1, 16'h0FC0,  128,      1'b0, 1'b0};
        vecs[9]  = '{1, 16'h0E00,  1,        1'b0, 1'b0};
        vecs[10] = '{1, 16'h0DC0,  0,        1'b0, 1'b1};
        vecs[11] = '{1, 16'h03C0,  8388608,  1'b0, 1'b0};
        vecs[12] = '{1, 16'h0400,  16777215, 1'b1, 1'b0};
        vecs[13] = '{1, 16'h0800,  0,        1'b0, 1'b1};
        vecs[14] = '{2, 16'd2,     257,      1'b0, 1'b0};
        vecs[15] = '{2, 16'd4,     258,      1'b0, 1'b0};
        vecs[16] = '{2, 16'd1024,  4096,     1'b0, 1'b0};
        vecs[17] = '{2, 16'd3,     258,      1'b0, 1'b0};

        // Reset held with live, valid input: everything must stay cleared.
        for (int c = 0; c < 4; c++)
            cycle(1'b1, 1'b1, 3'b111, 16'($urandom), 16'($urandom), 16'($urandom));

        first_valid = -1;
        for (int c = 1; c <= 8; c++) begin
            cycle(1'b0, 1'b1, 3'b111, 16'($urandom), 16'($urandom), 16'($urandom));
            if (ov[0] && first_valid < 0) first_valid = c;
        end
        check("first out_valid cycle after reset", longint'(first_valid), 3);

        // Fixed vectors, streamed back-to-back; each result is due two loop steps later.
        for (int i = 0; i < NV + 2; i++) begin
            vv = 3'b000;
            d[0] = '0;
            d[1] = '0;
            d[2] = '0;
            if (i < NV) begin
                vv[vecs[i].dut] = 1'b1;
                d[vecs[i].dut]  = vecs[i].din;
            end
            cycle(1'b0, 1'b1, vv, d[0], d[1], d[2]);
            if (i >= 2) begin
                int j;
                int u;
                j = i - 2;
                u = vecs[j].dut;
                check($sformatf("vec%0d out_valid", j), longint'(ov[u]), 1);
                check($sformatf("vec%0d dout", j), longint'(dq[u]), vecs[j].dout);
                check($sformatf("vec%0d sat", j), longint'(sq[u]), longint'(vecs[j].sat));
                check($sformatf("vec%0d uflow", j), longint'(uq[u]), longint'(vecs[j].uflow));
            end
        end

        // Stall: stream an incrementing din through an ena pattern, then drain.
        n = 0;
        for (int c = 0; c < 4; c++) begin
            cycle(1'b0, 1'b1, 3'b111, 16'(n), 16'(n), 16'(n));
            n++;
        end
        for (int c = 0; c < 7; c++) begin
            cycle(1'b0, stall_pat[c], 3'b111, 16'(n), 16'(n), 16'(n));
            n++;
        end
        for (int c = 0; c < 4; c++) begin
            cycle(1'b0, 1'b1, 3'b111, 16'(n), 16'(n), 16'(n));
            n++;
        end

        // Reset while stalled, then stay stalled: valids must be cleared and stay cleared.
        cycle(1'b0, 1'b0, 3'b111, 16'(n), 16'(n), 16'(n));
        cycle(1'b1, 1'b0, 3'b111, 16'(n), 16'(n), 16'(n));
        check("out_valid after reset in stall", longint'(ov[0]), 0);
        cycle(1'b0, 1'b0, 3'b111, 16'(n), 16'(n), 16'(n));
        cycle(1'b0, 1'b0, 3'b111, 16'(n), 16'(n), 16'(n));
        for (int c = 0; c < 4; c++)
            cycle(1'b0, 1'b1, 3'b111, 16'(c), 16'(c), 16'(c));

        // Random traffic: valid, ena and the occasional reset all vary.
        for (int c = 0; c < 1500; c++) begin
            cycle($urandom_range(99) == 0, $urandom_range(99) < 80,
                  3'($urandom_range(7)),
                  16'($urandom), 16'($urandom), 16'($urandom));
        end
        for (int c = 0; c < 4; c++)
            cycle(1'b0, 1'b1, 3'b000, 16'd0, 16'd0, 16'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
